jk_cmd_driver: RTL and testbench
================================

Name: jk_cmd_driver

Overview:
- Command-sequenced stimulus driver that sits directly upstream of the lab JK flip-flop (`jk_ff`) and generates its `j`/`k` inputs.
- Accepts queued commands over a valid/ready interface. Each command is an operation {HOLD, RESET, SET, TOGGLE} plus a repeat length; the block drives the matching `j`/`k` pattern for that many clock cycles.
- Keeps a cycle-exact shadow model of the downstream flop's `q` for self-checking benches.

Parameters:
- DEPTH, 4, command FIFO entries; power of 2, minimum 2.
- LEN_W, 4, width of the repeat-length field.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous active-high reset.
- cmd_valid  input  1  command present on cmd_op/cmd_len.
- cmd_ready  output  1  FIFO can accept a command.
- cmd_op  input  2  operation {j,k}: 00 HOLD, 01 RESET, 10 SET, 11 TOGGLE.
- cmd_len  input  LEN_W  drive cycles; 0 is treated as 1.
- j  output  1  registered J to downstream flop.
- k  output  1  registered K to downstream flop.
- q_model  output  1  shadow of downstream q.
- done  output  1  one-cycle pulse when a command finishes.
- busy  output  1  FIFO non-empty or a command is executing.
- fill  output  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (async; takes effect immediately on rst rising, independent of clk):
  - j=0, k=0, q_model=0, done=0, busy=0, fill=0.
  - FIFO pointers cleared; FSM goes to IDLE.
  - cmd_ready=0 while rst=1, and 1 in the first cycle after release.
- FIFO push:
  - cmd_ready = !full && !rst.
  - A push occurs on an edge where cmd_valid && cmd_ready.
  - When full, a pop on the same edge does not open a slot that cycle: cmd_ready reflects only the pre-edge occupancy.
  - Push and pop on the same edge leave fill unchanged.
- FSM states: IDLE, DRIVE.
- IDLE:
  - j=k=0.
  - If the FIFO is non-empty at an edge: pop the head, load j,k from the op, set remaining to len (0→1), go to DRIVE.
  - Latency: a command accepted at edge E0 drives j/k from edge E0+1. No extra cycle is needed when the FIFO was empty.
- DRIVE:
  - At each edge, remaining decrements.
  - When remaining==1 at an edge:
    - done=1 for exactly the following cycle.
    - If the FIFO is non-empty, pop and load the next command on that same edge, with no j=k=0 gap; stay in DRIVE.
    - Otherwise j,k←0 and go to IDLE.
- Each command holds its j/k for exactly max(len,1) consecutive cycles.
- q_model updates on every rising edge (any state) from the current j/k:
  - 00: hold.
  - 01: 0.
  - 10: 1.
  - 11: invert.
  - This matches a JK flop on the same clk/rst, so q_model equals downstream q at all times.
- busy = (state==DRIVE) || (fill!=0).
- cmd_op/cmd_len are sampled only at push; later input changes do not affect queued commands.
- Reset mid-DRIVE:
  - Current and queued commands are discarded; no done pulse.
  - After release the block stays in IDLE until a new push.
- Maximum length is 2^LEN_W−1 cycles; there is no wrap beyond that.

Test Plan:
- Reset: rst=1 for 20 ns with cmd_valid=1 → j=0, k=0, q_model=0, cmd_ready=0, fill=0 throughout; no push recorded after release.
- Single SET (op 10, len 3) accepted at edge E0 → j=1,k=0 during cycles after E0+1..E0+3; q_model=1 after E0+2; done high only in the cycle after E0+3; j=k=0 from E0+4.
- Back-to-back (TOGGLE len 2, then RESET len 1, pushed on consecutive edges) → j/k = 11, 11, 01 with no gap; q_model sequence 0→1→0→0; done pulses after the 2nd and 3rd drive edges; busy falls with the final done.
- Full FIFO (DEPTH=4, six HOLD len 15 commands offered continuously) → five accepted (1 executing + 4 queued), cmd_ready=0 with fill=4; the sixth is accepted on the edge after command 1's done pops command 2.
- len=0 (SET, len 0) → exactly one cycle of j=1,k=0; q_model=1; single done pulse.
- Async reset mid-DRIVE (TOGGLE len 10, rst raised 5 ns after a clock edge in the 4th drive cycle) → j, k, q_model, done all 0 within 2 ns without a clock edge; fill=0; after release no j/k activity for 5 idle cycles.

Source files
------------

// File: rtl/jk_cmd_if.sv
// jk_cmd_if: command handshake between a stimulus source and jk_cmd_driver.
//   cmd_valid  source -> driver  command present on cmd_op/cmd_len
//   cmd_ready  driver -> source  driver FIFO can take a command this edge
//   cmd_op     source -> driver  {j,k}: 00 HOLD, 01 RESET, 10 SET, 11 TOGGLE
//   cmd_len    source -> driver  drive cycles (0 behaves as 1)
interface jk_cmd_if #(
    parameter int LEN_W = 4
) ();
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [LEN_W-1:0] cmd_len;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_len,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_len,
        output cmd_ready
    );
endinterface

// File: rtl/jk_cmd_driver.sv
// jk_cmd_driver: queues {op,len} commands and drives the j/k inputs of a
// downstream JK flop, holding each pattern for max(len,1) cycles. Keeps a
// cycle-exact shadow (q_model) of the downstream flop's q.
//   clk, rst   clock, asynchronous active-high reset
//   cmd        jk_cmd_if slave: cmd_valid/cmd_ready/cmd_op/cmd_len
//   j, k       registered JK drive
//   q_model    shadow of downstream q
//   done       high during the last drive cycle of each command
//   busy       command executing or FIFO non-empty
//   fill       FIFO occupancy
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no command executing, j=k=0
// ST_DRIVE | driving the current command's j/k, rem_q cycles left
module jk_cmd_driver #(
    parameter int DEPTH = 4,
    parameter int LEN_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    jk_cmd_if.slave                  cmd,
    output logic                     j,
    output logic                     k,
    output logic                     q_model,
    output logic                     done,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fill
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = LEN_W + 2;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_DRIVE = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             j_q, j_d;
    logic             k_q, k_d;
    logic             q_model_q, q_model_d;
    logic             done_q, done_d;
    logic [EW-1:0]    mem_q [DEPTH];

    logic [AW:0]      fill_w;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic [EW-1:0]    head;
    logic [LEN_W-1:0] head_len_eff;

    // Extra pointer bit distinguishes full from empty.
    assign fill_w = wr_ptr_q - rd_ptr_q;
    assign empty  = (fill_w == '0);
    assign full   = (fill_w == (AW+1)'(DEPTH));

    // Ready depends only on pre-edge occupancy; a same-edge pop never
    // opens a slot for a push when full.
    assign cmd.cmd_ready = !full && !rst;
    assign push          = cmd.cmd_valid && cmd.cmd_ready;

    assign head         = mem_q[rd_ptr_q[AW-1:0]];
    assign head_len_eff = (head[LEN_W-1:0] == '0) ? LEN_W'(1) : head[LEN_W-1:0];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {cmd.cmd_op, cmd.cmd_len};
        end
    end

    always_comb begin
        state_d = state_q;
        j_d     = j_q;
        k_d     = k_q;
        rem_d   = rem_q;
        pop     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                j_d = 1'b0;
                k_d = 1'b0;
                if (!empty) begin
                    pop     = 1'b1;
                    j_d     = head[EW-1];
                    k_d     = head[EW-2];
                    rem_d   = head_len_eff;
                    state_d = ST_DRIVE;
                end
            end
            default: begin
                if (rem_q == LEN_W'(1)) begin
                    if (!empty) begin
                        // Chain straight into the next command, no idle gap.
                        pop   = 1'b1;
                        j_d   = head[EW-1];
                        k_d   = head[EW-2];
                        rem_d = head_len_eff;
                    end else begin
                        j_d     = 1'b0;
                        k_d     = 1'b0;
                        state_d = ST_IDLE;
                    end
                end else begin
                    rem_d = rem_q - LEN_W'(1);
                end
            end
        endcase

        // done marks the final cycle a command's pattern is on j/k.
        done_d = (state_d == ST_DRIVE) && (rem_d == LEN_W'(1));

        wr_ptr_d = wr_ptr_q + (AW+1)'(push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
    end

    // Shadow JK flop, fed by the same registered j/k the downstream sees.
    always_comb begin
        case ({j_q, k_q})
            2'b01:   q_model_d = 1'b0;
            2'b10:   q_model_d = 1'b1;
            2'b11:   q_model_d = ~q_model_q;
            default: q_model_d = q_model_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rem_q     <= '0;
            j_q       <= 1'b0;
            k_q       <= 1'b0;
            q_model_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            rem_q     <= rem_d;
            j_q       <= j_d;
            k_q       <= k_d;
            q_model_q <= q_model_d;
            done_q    <= done_d;
        end
    end

    assign j       = j_q;
    assign k       = k_q;
    assign q_model = q_model_q;
    assign done    = done_q;
    assign fill    = fill_w;
    assign busy    = (state_q == ST_DRIVE) || !empty;
endmodule

// File: tb/tb_jk_cmd_driver.sv
`timescale 1ns/1ps
module tb_jk_cmd_driver;
    logic       clk;
    logic       rst;
    logic       j, k, q_model, done, busy;
    logic [2:0] fill;
    int         n_total;
    int         n_pass;

    jk_cmd_if #(.LEN_W(4)) cmd_if ();

    jk_cmd_driver #(.DEPTH(4), .LEN_W(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .cmd     (cmd_if),
        .j       (j),
        .k       (k),
        .q_model (q_model),
        .done    (done),
        .busy    (busy),
        .fill    (fill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;

        // Reset held with a command offered
        rst = 1'b1;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = 2'b10;
        cmd_if.cmd_len   = 4'd3;
        #2;
        chk("rst_j", j, 0);
        chk("rst_k", k, 0);
        chk("rst_q", q_model, 0);
        chk("rst_ready", cmd_if.cmd_ready, 0);
        chk("rst_fill", fill, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        step();
        chk("rst_edge_ready", cmd_if.cmd_ready, 0);
        chk("rst_edge_fill", fill, 0);
        chk("rst_edge_j", j, 0);
        #14;
        rst = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        #1;
        chk("rel_ready", cmd_if.cmd_ready, 1);
        step();
        chk("rel_fill", fill, 0);
        chk("rel_busy", busy, 0);

        // Single SET len 3
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = 2'b10;
        cmd_if.cmd_len   = 4'd3;
        step();
        chk("set_push_fill", fill, 1);
        chk("set_push_j", j, 0);
        chk("set_push_busy", busy, 1);
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = 2'b11;
        cmd_if.cmd_len   = 4'd0;
        step();
        chk("set_c1_jk", {j, k}, 2'b10);
        chk("set_c1_q", q_model, 0);
        chk("set_c1_done", done, 0);
        chk("set_c1_fill", fill, 0);
        step();
        chk("set_c2_jk", {j, k}, 2'b10);
        chk("set_c2_q", q_model, 1);
        chk("set_c2_done", done, 0);
        step();
        chk("set_c3_jk", {j, k}, 2'b10);
        chk("set_c3_done", done, 1);
        chk("set_c3_q", q_model, 1);
        step();
        chk("set_end_jk", {j, k}, 2'b00);
        chk("set_end_done", done, 0);
        chk("set_end_q", q_model, 1);
        chk("set_end_busy", busy, 0);

        // Back-to-back TOGGLE len 2, RESET len 1
        reset_pulse();
        chk("b2b_rst_q", q_model, 0);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = 2'b11;
        cmd_if.cmd_len   = 4'd2;
        step();
        chk("b2b_push_fill", fill, 1);
        cmd_if.cmd_op  = 2'b01;
        cmd_if.cmd_len = 4'd1;
        step();
        cmd_if.cmd_valid = 1'b0;
        chk("b2b_c1_jk", {j, k}, 2'b11);
        chk("b2b_c1_q", q_model, 0);
        chk("b2b_c1_done", done, 0);
        chk("b2b_c1_fill", fill, 1);
        step();
        chk("b2b_c2_jk", {j, k}, 2'b11);
        chk("b2b_c2_q", q_model, 1);
        chk("b2b_c2_done", done, 1);
        step();
        chk("b2b_c3_jk", {j, k}, 2'b01);
        chk("b2b_c3_q", q_model, 0);
        chk("b2b_c3_done", done, 1);
        chk("b2b_c3_busy", busy, 1);
        step();
        chk("b2b_end_jk", {j, k}, 2'b00);
        chk("b2b_end_q", q_model, 0);
        chk("b2b_end_done", done, 0);
        chk("b2b_end_busy", busy, 0);

        // len 0 behaves as 1
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = 2'b10;
        cmd_if.cmd_len   = 4'd0;
        step();
        chk("len0_push_fill", fill, 1);
        cmd_if.cmd_valid = 1'b0;
        step();
        chk("len0_c1_jk", {j, k}, 2'b10);
        chk("len0_c1_done", done, 1);
        chk("len0_c1_q", q_model, 0);
        step();
        chk("len0_end_jk", {j, k}, 2'b00);
        chk("len0_end_done", done, 0);
        chk("len0_end_q", q_model, 1);
        chk("len0_end_busy", busy, 0);
        step();
        chk("len0_idle_done", done, 0);
        chk("len0_idle_q", q_model, 1);

        // Full FIFO: six HOLD len 15 offered continuously
        reset_pulse();
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = 2'b00;
        cmd_if.cmd_len   = 4'd15;
        step();
        chk("full_e1_fill", fill, 1);
        step();
        chk("full_e2_fill", fill, 1);
        chk("full_e2_busy", busy, 1);
        step();
        step();
        chk("full_e4_fill", fill, 3);
        step();
        chk("full_e5_fill", fill, 4);
        chk("full_e5_ready", cmd_if.cmd_ready, 0);
        for (int i = 6; i <= 15; i++) step();
        chk("full_e15_done", done, 0);
        step();
        chk("full_e16_done", done, 1);
        chk("full_e16_fill", fill, 4);
        chk("full_e16_ready", cmd_if.cmd_ready, 0);
        step();
        chk("full_e17_done", done, 0);
        chk("full_e17_fill", fill, 3);
        chk("full_e17_ready", cmd_if.cmd_ready, 1);
        chk("full_e17_jk", {j, k}, 2'b00);
        step();
        chk("full_e18_fill", fill, 4);
        chk("full_e18_ready", cmd_if.cmd_ready, 0);
        cmd_if.cmd_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("full_rst_fill", fill, 0);
        chk("full_rst_busy", busy, 0);
        #2;
        rst = 1'b0;

        // Async reset mid-DRIVE
        step();
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = 2'b11;
        cmd_if.cmd_len   = 4'd10;
        step();
        chk("arst_push_fill", fill, 1);
        cmd_if.cmd_valid = 1'b0;
        step();
        chk("arst_c1_q", q_model, 0);
        step();
        chk("arst_c2_q", q_model, 1);
        step();
        chk("arst_c3_q", q_model, 0);
        step();
        chk("arst_c4_jk", {j, k}, 2'b11);
        chk("arst_c4_q", q_model, 1);
        chk("arst_c4_done", done, 0);
        #4;
        rst = 1'b1;
        #1;
        chk("arst_j", j, 0);
        chk("arst_k", k, 0);
        chk("arst_q", q_model, 0);
        chk("arst_done", done, 0);
        chk("arst_fill", fill, 0);
        chk("arst_busy", busy, 0);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("arst_idle_jk", {j, k}, 2'b00);
            chk("arst_idle_done", done, 0);
            chk("arst_idle_busy", busy, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
